gemm_job_scheduler: RTL
=======================

Name: gemm_job_scheduler

Overview:
- Shares the single GeMM controller and 1-MAC datapath between NumReq requesters, each submitting M/K/N job descriptors.
- Round-robin arbitration picks a requester; the block validates the sizes, pulses start, holds sizes stable while the controller runs, and returns a per-requester completion or error response.
- Sits between the host/config requesters and the controller inside the accelerator top.

Parameters:
- AddrWidth, 16, width of the size fields; matches the controller counters.
- NumReq, 2, number of requesters (>=2).
- JobCntWidth, 16, width of the completed-job counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NumReq  per-requester descriptor valid
- req_ready_o  out  NumReq  per-requester descriptor accept
- req_m_size_i  in  NumReq x AddrWidth  M per requester
- req_k_size_i  in  NumReq x AddrWidth  K per requester
- req_n_size_i  in  NumReq x AddrWidth  N per requester
- rsp_valid_o  out  NumReq  one-cycle completion pulse to the owning requester
- rsp_error_o  out  1  qualifies rsp_valid_o; 1 = descriptor rejected
- gemm_start_o  out  1  start pulse to the controller
- gemm_m_size_o / gemm_k_size_o / gemm_n_size_o  out  AddrWidth each  sizes to the controller
- gemm_done_i  in  1  controller done pulse
- grant_id_o  out  $clog2(NumReq)  index of the current job owner
- busy_o  out  1  scheduler not Idle
- jobs_done_o  out  JobCntWidth  count of successfully completed jobs

Behaviour:
- Reset: all outputs 0; state Idle; RR pointer = NumReq-1, so requester 0 has first priority; latched descriptor 0.
- States: Idle, Issue, Run, Respond.
- Idle:
  - Arbiter grants the first asserted req_valid_i, searching from pointer+1 mod NumReq.
  - req_ready_o[g] = 1 combinationally, only for the winner and only in Idle; all ready bits are 0 in every other state.
  - Handshake at cycle T latches M/K/N and g; grant_id_o updates at T+1.
  - Validation on the latched values: reject if K==0, N==0, M==0, N[1:0]!=0, or (M>=4 and M[1:0]!=0). M in 1..3 is legal.
  - Invalid descriptor -> Respond with error; valid -> Issue.
- Issue: gemm_start_o = 1 for exactly one cycle (T+1) -> Run.
- Run: wait for gemm_done_i, then go to Respond. No timeout.
- Respond (cycle D+1 after done at D, or T+1 for a rejected job):
  - rsp_valid_o[grant] = 1 for one cycle.
  - rsp_error_o = reject flag.
  - jobs_done_o increments only on success; wraps modulo 2^JobCntWidth.
  - RR pointer <= grant.
  - Next state Idle.
- gemm_*_size_o are registered copies of the latched descriptor. They are stable from Issue through Respond and hold their last value in Idle. A rejected job never updates them and never pulses start.
- gemm_done_i outside Run is ignored.
- busy_o = (state != Idle).
- Requesters must hold valid and sizes until ready. Dropping valid before ready is legal and the request simply loses.
- New requests seen in Respond are not granted until the following Idle cycle, so back-to-back jobs have a minimum one-cycle Idle gap.
- Reset asserted in any state aborts immediately to reset values; the in-flight job gets no response.
- Latency: handshake to start = 1 cycle; done to rsp_valid = 1 cycle; rejection to rsp_valid = 1 cycle.

Decomposition:
- gemm_sched_pkg contains:
  - sched_state_t enum (Idle, Issue, Run, Respond)
  - gemm_job_t packed struct {m, k, n}
  - the size-check function job_is_valid()
- One sub-module, gemm_rr_arbiter (parameter NumReq; inputs req, pointer; outputs grant index and grant_valid), combinational.

Test Plan:
1. Req0 sends M=8,K=4,N=8; controller model pulses done 20 cycles after start -> start at T+1 only; sizes stable 8/4/8; rsp_valid_o[0] at done+1 with error 0; jobs_done_o=1.
2. Req0 and req1 hold valid continuously, 4 jobs each -> grants alternate 0,1,0,1,...; never two ready bits at once; jobs_done_o=8.
3. Req1 sends M=8,K=4,N=6 -> rsp_valid_o[1] at T+1 with rsp_error_o=1; no gemm_start_o; gemm sizes unchanged; jobs_done_o unchanged.
4. M=2,K=3,N=4 is accepted; M=6,K=3,N=4 and K=0 are each rejected with error=1.
5. rst_i asserted mid-Run -> all outputs 0 the same cycle; after release with both requesting, req0 is granted first and the stale done pulse is ignored.
6. gemm_done_i pulsed while Idle, and a request dropped before ready -> no state change, no response, busy_o stays 0.

Source files
------------

// File: rtl/gemm_sched_pkg.sv
// ---------------------------------------------------------------------------
// gemm_sched_pkg
// Shared types and helpers for the GeMM job scheduler.
//   sched_state_t : scheduler FSM states (Idle, Issue, Run, Respond)
//   gemm_job_t    : one M/K/N job descriptor. Fields are MaxAddrWidth wide so
//                   that any AddrWidth up to MaxAddrWidth fits after zero
//                   extension.
//   job_is_valid(): size legality check applied to every accepted descriptor
// ---------------------------------------------------------------------------
package gemm_sched_pkg;

  localparam int MaxAddrWidth = 32;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Issue   = 2'd1,
    Run     = 2'd2,
    Respond = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] m;
    logic [MaxAddrWidth-1:0] k;
    logic [MaxAddrWidth-1:0] n;
  } gemm_job_t;

  // The datapath walks N in groups of four and M either as a short tail of
  // 1..3 rows or in whole groups of four. Any zero dimension is meaningless.
  function automatic logic job_is_valid(input gemm_job_t job);
    logic bad;
    bad = (job.k == '0) ||
          (job.n == '0) ||
          (job.m == '0) ||
          (job.n[1:0] != 2'b00) ||
          ((job.m >= MaxAddrWidth'(4)) && (job.m[1:0] != 2'b00));
    return !bad;
  endfunction

endpackage

// File: rtl/gemm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// gemm_rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the
// requester just after ptr_i and wraps, so the requester named by ptr_i
// (the last one served) has the lowest priority.
//   req_i         : per-requester request bits
//   ptr_i         : index of the most recently served requester
//   grant_o       : index of the winner (0 when nobody requests)
//   grant_valid_o : at least one request is present
// ---------------------------------------------------------------------------
module gemm_rr_arbiter #(
  parameter int NumReq   = 2,
  parameter int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] grant_o,
  output logic                grant_valid_o
);

  int                  candSum;
  logic [IdxWidth-1:0] candIdx;

  // Walk the requesters in priority order, starting one past the pointer,
  // and keep the first one that is asking. The modulo is done by a single
  // conditional subtract because the sum never reaches 2*NumReq.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    candSum       = 0;
    candIdx       = '0;
    for (int off = 1; off <= NumReq; off++) begin
      candSum = int'(ptr_i) + off;
      if (candSum >= NumReq) begin
        candSum = candSum - NumReq;
      end
      candIdx = IdxWidth'(candSum);
      if (!grant_valid_o && req_i[candIdx]) begin
        grant_valid_o = 1'b1;
        grant_o       = candIdx;
      end
    end
  end

endmodule

// File: rtl/gemm_job_scheduler.sv
// ---------------------------------------------------------------------------
// gemm_job_scheduler
// Shares one GeMM controller between NumReq requesters. A round-robin
// arbiter picks a requester while Idle, the descriptor is checked, legal jobs
// get a one-cycle start pulse and are held until the controller reports done,
// and every accepted descriptor gets exactly one response pulse (with an
// error flag for rejected sizes).
//
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   req_valid_i         : per-requester descriptor valid
//   req_ready_o         : per-requester accept (only the Idle winner)
//   req_m/k/n_size_i    : per-requester job sizes
//   rsp_valid_o         : one-cycle response pulse to the job owner
//   rsp_error_o         : qualifies rsp_valid_o, 1 = descriptor rejected
//   gemm_start_o        : start pulse to the controller
//   gemm_m/k/n_size_o   : sizes of the last accepted legal job
//   gemm_done_i         : controller done pulse (only honoured in Run)
//   grant_id_o          : owner of the current/last job
//   busy_o              : scheduler is not Idle
//   jobs_done_o         : successfully completed jobs (wraps)
// ---------------------------------------------------------------------------
module gemm_job_scheduler
  import gemm_sched_pkg::*;
#(
  parameter int AddrWidth   = 16,
  parameter int NumReq      = 2,
  parameter int JobCntWidth = 16,
  parameter int IdxWidth    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_m_size_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_k_size_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_n_size_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  output logic                             rsp_error_o,
  output logic                             gemm_start_o,
  output logic [AddrWidth-1:0]             gemm_m_size_o,
  output logic [AddrWidth-1:0]             gemm_k_size_o,
  output logic [AddrWidth-1:0]             gemm_n_size_o,
  input  logic                             gemm_done_i,
  output logic [IdxWidth-1:0]              grant_id_o,
  output logic                             busy_o,
  output logic [JobCntWidth-1:0]           jobs_done_o
);

  sched_state_t         state_q, state_d;
  logic [IdxWidth-1:0]  grant_q;
  logic [IdxWidth-1:0]  ptr_q;
  logic                 reject_q;
  logic [AddrWidth-1:0] gemmM_q, gemmK_q, gemmN_q;
  logic [JobCntWidth-1:0] jobCnt_q;

  logic [IdxWidth-1:0]  arbGrant;
  logic                 arbValid;
  logic                 acceptJob;
  logic                 candLegal;
  gemm_job_t            candJob;
  logic [NumReq-1:0]    readyVec;
  logic [NumReq-1:0]    rspVec;

  gemm_rr_arbiter #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_arbiter (
    .req_i         (req_valid_i),
    .ptr_i         (ptr_q),
    .grant_o       (arbGrant),
    .grant_valid_o (arbValid)
  );

  // The winner's descriptor is checked in the handshake cycle itself; those
  // are exactly the values being latched, so the verdict can steer the very
  // next state (Issue or straight to Respond).
  always_comb begin
    candJob   = '0;
    candJob.m = MaxAddrWidth'(req_m_size_i[arbGrant]);
    candJob.k = MaxAddrWidth'(req_k_size_i[arbGrant]);
    candJob.n = MaxAddrWidth'(req_n_size_i[arbGrant]);
    candLegal = job_is_valid(candJob);
  end

  // Next-state and handshake logic. Ready is only ever offered to the
  // arbitration winner while Idle, so a request arriving in Respond waits
  // for the following Idle cycle. Ready is also forced low during reset so
  // that every output reads zero while rst_i is high.
  always_comb begin
    state_d   = state_q;
    readyVec  = '0;
    acceptJob = 1'b0;
    unique case (state_q)
      Idle: begin
        if (arbValid && !rst_i) begin
          readyVec[arbGrant] = 1'b1;
          acceptJob          = 1'b1;
          state_d            = candLegal ? Issue : Respond;
        end
      end
      Issue: begin
        state_d = Run;
      end
      Run: begin
        if (gemm_done_i) begin
          state_d = Respond;
        end
      end
      Respond: begin
        state_d = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
  end

  // State register plus the job bookkeeping. Controller sizes are only
  // overwritten by a legal descriptor, so a rejected job leaves the
  // controller looking at the previous job. The round-robin pointer moves
  // to the owner when its response goes out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= Idle;
      grant_q  <= '0;
      ptr_q    <= IdxWidth'(NumReq - 1);
      reject_q <= 1'b0;
      gemmM_q  <= '0;
      gemmK_q  <= '0;
      gemmN_q  <= '0;
      jobCnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (acceptJob) begin
        grant_q  <= arbGrant;
        reject_q <= !candLegal;
        if (candLegal) begin
          gemmM_q <= req_m_size_i[arbGrant];
          gemmK_q <= req_k_size_i[arbGrant];
          gemmN_q <= req_n_size_i[arbGrant];
        end
      end
      if (state_q == Respond) begin
        ptr_q <= grant_q;
        if (!reject_q) begin
          jobCnt_q <= jobCnt_q + JobCntWidth'(1);
        end
      end
    end
  end

  // Response pulse goes to the recorded owner for the single Respond cycle.
  always_comb begin
    rspVec = '0;
    if (state_q == Respond) begin
      rspVec[grant_q] = 1'b1;
    end
  end

  assign req_ready_o   = readyVec;
  assign rsp_valid_o   = rspVec;
  assign rsp_error_o   = (state_q == Respond) && reject_q;
  assign gemm_start_o  = (state_q == Issue);
  assign gemm_m_size_o = gemmM_q;
  assign gemm_k_size_o = gemmK_q;
  assign gemm_n_size_o = gemmN_q;
  assign grant_id_o    = grant_q;
  assign busy_o        = (state_q != Idle);
  assign jobs_done_o   = jobCnt_q;

endmodule
